flappy_render: RTL and testbench



---
 rtl/flappy_pkg.sv | 30 +++
 rtl/flappy_frame_ctl.sv | 62 ++++++
 rtl/flappy_render.sv | 108 ++++++++++
 tb/tb_flappy_render.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/flappy_pkg.sv
// Shared constants and the object-state bundle for the flappy pixel source.
// Colours are 12-bit bbbb_gggg_rrrr.
package flappy_pkg;
    localparam int H_RES = 640;
    localparam int V_RES = 480;
    localparam logic [9:0] LAST_COL = 10'(H_RES - 1);
    localparam logic [8:0] LAST_ROW = 9'(V_RES - 1);

    localparam logic [11:0] SKY       = 12'hEC4;
    localparam logic [11:0] GROUND_A  = 12'h4C9;
    localparam logic [11:0] GROUND_B  = 12'h5AD;
    localparam logic [11:0] PIPE      = 12'h2B3;
    localparam logic [11:0] PIPE_EDGE = 12'h160;
    localparam logic [11:0] BIRD      = 12'h1DF;
    localparam logic [11:0] WING      = 12'h09E;

    typedef struct packed {
        logic [8:0]  bird_y;
        logic [10:0] pipe0_x;
        logic [8:0]  pipe0_gap;
        logic [10:0] pipe1_x;
        logic [8:0]  pipe1_gap;
        logic        game_over;
    } obj_state_t;

    // Halve every colour channel for the game-over tint.
    function automatic logic [11:0] darken(input logic [11:0] c);
        return {1'b0, c[11:9], 1'b0, c[7:5], 1'b0, c[3:1]};
    endfunction
endpackage

// File: rtl/flappy_frame_ctl.sv
// Frame bookkeeping: ACTIVE/VBLANK FSM, frame_end pulse, frame counter, ground
// scroll and the shadow copy of the game state taken during blanking.
module flappy_frame_ctl
    import flappy_pkg::*;
#(
    parameter int SCROLL_STEP = 2
) (
    input  logic       vga_clk,
    input  logic       rst,
    input  logic [8:0] row_addr,
    input  logic [9:0] col_addr,
    input  logic       rdn,
    input  logic       state_vld,
    input  obj_state_t obj_in,
    output obj_state_t obj_q,
    output logic       wing_phase,
    output logic [3:0] scroll,
    output logic       state_ack,
    output logic       frame_end
);
    localparam logic ST_ACTIVE = 1'b0;
    localparam logic ST_VBLANK = 1'b1;

    logic       state;
    logic       latched;
    logic [7:0] frame_cnt;
    logic       last_pix;
    logic       do_latch;

    assign last_pix   = !rdn && (row_addr == LAST_ROW) && (col_addr == LAST_COL);
    // A visible pixel in the same cycle always beats the latch.
    assign do_latch   = (state == ST_VBLANK) && state_vld && !latched && rdn;
    assign wing_phase = frame_cnt[3];

    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            state     <= ST_VBLANK;
            latched   <= 1'b0;
            frame_cnt <= 8'd0;
            scroll    <= 4'd0;
            state_ack <= 1'b0;
            frame_end <= 1'b0;
            obj_q     <= '0;
        end else begin
            frame_end <= last_pix;
            state_ack <= do_latch;
            if (frame_end) begin
                state     <= ST_VBLANK;
                latched   <= 1'b0;
                frame_cnt <= frame_cnt + 8'd1;
                if (!obj_q.game_over)
                    scroll <= scroll + 4'(SCROLL_STEP);
            end else if (state == ST_VBLANK && !rdn) begin
                state <= ST_ACTIVE;
            end
            if (do_latch) begin
                obj_q   <= obj_in;
                latched <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/flappy_render.sv
// Zero-latency pixel source for the VGA controller: sky, scrolling ground,
// two pipes and the bird, drawn from the shadowed game state.
module flappy_render
    import flappy_pkg::*;
#(
    parameter int BIRD_COL    = 160,
    parameter int PIPE_W      = 52,
    parameter int GAP_H       = 100,
    parameter int GROUND_ROW  = 420,
    parameter int SCROLL_STEP = 2
) (
    input  logic        vga_clk,
    input  logic        rst,
    input  logic [8:0]  row_addr,
    input  logic [9:0]  col_addr,
    input  logic        rdn,
    input  logic        state_vld,
    input  logic [8:0]  bird_y,
    input  logic [10:0] pipe0_x,
    input  logic [8:0]  pipe0_gap,
    input  logic [10:0] pipe1_x,
    input  logic [8:0]  pipe1_gap,
    input  logic        game_over,
    output logic        state_ack,
    output logic        frame_end,
    output logic [11:0] d_in_BGR
);
    localparam logic [9:0]         BIRD_L     = 10'(BIRD_COL);
    localparam logic [9:0]         BIRD_R     = 10'(BIRD_COL + 23);
    localparam logic [9:0]         WING_R     = 10'(BIRD_COL + 9);
    localparam logic [8:0]         GROUND_R9  = 9'(GROUND_ROW);
    localparam logic [9:0]         GAP_SPAN   = 10'(GAP_H - 1);
    localparam logic signed [11:0] PIPE_SPAN  = 12'(PIPE_W - 1);
    localparam logic signed [11:0] EDGE_W     = 12'sd2;

    obj_state_t obj_in;
    obj_state_t obj;
    logic       wing_phase;
    logic [3:0] scroll;

    assign obj_in = {bird_y, pipe0_x, pipe0_gap, pipe1_x, pipe1_gap, game_over};

    flappy_frame_ctl #(.SCROLL_STEP(SCROLL_STEP)) u_ctl (
        .vga_clk    (vga_clk),
        .rst        (rst),
        .row_addr   (row_addr),
        .col_addr   (col_addr),
        .rdn        (rdn),
        .state_vld  (state_vld),
        .obj_in     (obj_in),
        .obj_q      (obj),
        .wing_phase (wing_phase),
        .scroll     (scroll),
        .state_ack  (state_ack),
        .frame_end  (frame_end)
    );

    // Returns {hit, on_edge}; 12-bit signed bounds let pipes slide off column 0.
    function automatic logic [1:0] pipe_hit(input logic [10:0] x, input logic [8:0] gap,
                                            input logic [9:0] col, input logic [8:0] row);
        logic signed [11:0] left, right, c;
        logic [9:0]         gap_top, gap_bot, row10;
        logic               hit, on_edge;
        left    = signed'({x[10], x});
        right   = left + PIPE_SPAN;
        c       = signed'({2'b00, col});
        row10   = {1'b0, row};
        gap_top = {1'b0, gap};
        gap_bot = gap_top + GAP_SPAN;
        hit     = (c >= left) && (c <= right) && (row10 < gap_top || row10 > gap_bot)
                  && (row < GROUND_R9);
        on_edge = (c <= left + EDGE_W) || (c >= right - EDGE_W);
        return {hit, on_edge};
    endfunction

    logic [9:0]  row10, bird_top, bird_bot;
    logic [3:0]  ground_phase;
    logic [1:0]  p0, p1;
    logic        in_bird, in_wing;
    logic [11:0] colour;

    assign row10        = {1'b0, row_addr};
    assign bird_top     = {1'b0, obj.bird_y};
    // 10-bit bottom keeps a low bird from wrapping back to row 0.
    assign bird_bot     = bird_top + 10'd16;
    assign ground_phase = col_addr[3:0] + scroll;
    assign p0           = pipe_hit(obj.pipe0_x, obj.pipe0_gap, col_addr, row_addr);
    assign p1           = pipe_hit(obj.pipe1_x, obj.pipe1_gap, col_addr, row_addr);
    assign in_bird      = (col_addr >= BIRD_L) && (col_addr <= BIRD_R)
                          && (row10 >= bird_top) && (row10 <= bird_bot);
    assign in_wing      = (col_addr <= WING_R) && (row10 >= bird_top + 10'd8)
                          && (row10 <= bird_top + 10'd11);

    always_comb begin
        colour = SKY;
        if (row_addr >= GROUND_R9)
            colour = ground_phase[3] ? GROUND_A : GROUND_B;
        if (p0[1])
            colour = p0[0] ? PIPE_EDGE : PIPE;
        else if (p1[1])
            colour = p1[0] ? PIPE_EDGE : PIPE;
        if (in_bird)
            colour = (in_wing && wing_phase) ? WING : BIRD;
        if (obj.game_over)
            colour = darken(colour);
        d_in_BGR = rdn ? 12'h000 : colour;
    end
endmodule

// File: tb/tb_flappy_render.sv
// Bench for flappy_render: a frame-level reference model predicts pixel,
// state_ack and frame_end for every driven cycle; a monitor compares them.
module tb_flappy_render;
  logic        vga_clk = 1'b0;
  logic        rst;
  logic [8:0]  row_addr;
  logic [9:0]  col_addr;
  logic        rdn;
  logic        state_vld;
  logic [8:0]  bird_y;
  logic [10:0] pipe0_x;
  logic [8:0]  pipe0_gap;
  logic [10:0] pipe1_x;
  logic [8:0]  pipe1_gap;
  logic        game_over;
  logic        state_ack;
  logic        frame_end;
  logic [11:0] d_in_BGR;

  // ---------------- clock / reset ----------------
  always #20 vga_clk = ~vga_clk;

  flappy_render dut (
    .vga_clk   (vga_clk),
    .rst       (rst),
    .row_addr  (row_addr),
    .col_addr  (col_addr),
    .rdn       (rdn),
    .state_vld (state_vld),
    .bird_y    (bird_y),
    .pipe0_x   (pipe0_x),
    .pipe0_gap (pipe0_gap),
    .pipe1_x   (pipe1_x),
    .pipe1_gap (pipe1_gap),
    .game_over (game_over),
    .state_ack (state_ack),
    .frame_end (frame_end),
    .d_in_BGR  (d_in_BGR)
  );

  // ---------------- reference model ----------------
  int m_frame_cnt, m_scroll;
  bit m_vblank, m_latched, m_fe, m_ack;
  int s_by, s_go;
  int s_px[2];
  int s_pg[2];

  function automatic int sx11(input logic [10:0] v);
    return v[10] ? int'(v) - 2048 : int'(v);
  endfunction

  task automatic model_reset();
    m_frame_cnt = 0; m_scroll = 0; m_vblank = 1; m_latched = 0; m_fe = 0; m_ack = 0;
    s_by = 0; s_go = 0;
    s_px[0] = 0; s_px[1] = 0; s_pg[0] = 0; s_pg[1] = 0;
  endtask

  function automatic logic [11:0] ref_pix(input int r, input int c, input bit rd);
    int col_v, x, g, blue, green, red;
    if (rd) return 12'h000;
    col_v = 'hEC4;
    if (r >= 420) col_v = (((c + m_scroll) / 8) % 2 == 1) ? 'h4C9 : 'h5AD;
    for (int p = 1; p >= 0; p--) begin
      x = s_px[p];
      g = s_pg[p];
      if (c >= x && c <= x + 51 && (r < g || r > g + 99) && r < 420)
        col_v = (c - x < 3 || x + 51 - c < 3) ? 'h160 : 'h2B3;
    end
    if (c >= 160 && c <= 183 && r >= s_by && r <= s_by + 16)
      col_v = (r >= s_by + 8 && r <= s_by + 11 && c <= 169 && (m_frame_cnt / 8) % 2 == 1)
              ? 'h09E : 'h1DF;
    if (s_go != 0) begin
      blue  = (col_v / 256) % 16;
      green = (col_v / 16) % 16;
      red   = col_v % 16;
      col_v = (blue / 2) * 256 + (green / 2) * 16 + red / 2;
    end
    return 12'(col_v);
  endfunction

  task automatic advance(input int r, input int c, input bit rd);
    bit last, latch;
    last  = !rd && r == 479 && c == 639;
    latch = m_vblank && state_vld && !m_latched && rd;
    if (m_fe) begin
      m_vblank = 1; m_latched = 0;
      m_frame_cnt = (m_frame_cnt + 1) % 256;
      if (s_go == 0) m_scroll = (m_scroll + 2) % 16;
    end else if (m_vblank && !rd) begin
      m_vblank = 0;
    end
    if (latch) begin
      s_by = int'(bird_y); s_go = int'(game_over);
      s_px[0] = sx11(pipe0_x); s_pg[0] = int'(pipe0_gap);
      s_px[1] = sx11(pipe1_x); s_pg[1] = int'(pipe1_gap);
      m_latched = 1;
    end
    m_ack = latch;
    m_fe  = last;
  endtask

  // ---------------- scoreboard ----------------
  logic [13:0] exp_q[$];   // {state_ack, frame_end, pixel}
  logic [13:0] e_rec;
  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp_v);
    checks++;
    if (act === exp_v) passed++;
    else $display("FAIL %s: got %h expected %h at row %0d col %0d t=%0t",
                  name, act, exp_v, row_addr, col_addr, $time);
  endtask

  always @(negedge vga_clk) begin
    if (exp_q.size() > 0) begin
      e_rec = exp_q.pop_front();
      chk("pixel", d_in_BGR, e_rec[11:0]);
      chk("state_ack", {11'd0, state_ack}, {11'd0, e_rec[13]});
      chk("frame_end", {11'd0, frame_end}, {11'd0, e_rec[12]});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int r, input int c, input bit rd);
    @(posedge vga_clk);
    #1;
    row_addr = r[8:0];
    col_addr = c[9:0];
    rdn      = rd;
    exp_q.push_back({m_ack, m_fe, ref_pix(r, c, rd)});
    advance(r, c, rd);
  endtask

  task automatic set_obj(input int by, input int p0x, input int p0g,
                         input int p1x, input int p1g, input bit go);
    bird_y    = by[8:0];
    pipe0_x   = p0x[10:0];
    pipe0_gap = p0g[8:0];
    pipe1_x   = p1x[10:0];
    pipe1_gap = p1g[8:0];
    game_over = go;
  endtask

  task automatic new_state();
    state_vld = 1'b1;
    cyc(479, 639, 1'b0);
    repeat (3) cyc(0, 0, 1'b1);
    state_vld = 1'b0;
  endtask

  task automatic end_frame();
    cyc(479, 639, 1'b0);
    cyc(0, 0, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; rdn = 1'b1; row_addr = '0; col_addr = '0; state_vld = 1'b0;
    set_obj(0, 0, 0, 0, 0, 1'b0);
    model_reset();
    repeat (3) @(posedge vga_clk);
    #1 rst = 1'b0;

    // Reset state, sky with zero shadows, blanking black.
    cyc(0, 0, 1'b1);
    cyc(100, 300, 1'b0);
    cyc(100, 300, 1'b1);

    // First frame end: pulse, scroll advance seen on ground pixels.
    cyc(430, 6, 1'b0);
    end_frame();
    cyc(0, 0, 1'b1);
    cyc(430, 6, 1'b0);

    // state_vld during ACTIVE is held off until blanking; only one ack.
    set_obj(200, 600, 0, 600, 0, 1'b0);
    state_vld = 1'b1;
    repeat (4) cyc(10, 10, 1'b0);
    cyc(479, 639, 1'b0);
    repeat (6) cyc(0, 0, 1'b1);
    state_vld = 1'b0;
    cyc(205, 170, 1'b0);

    // Pipe clipped at column 0.
    set_obj(200, -40, 150, 400, 150, 1'b0);
    new_state();
    cyc(50, 5, 1'b0);
    cyc(50, 10, 1'b0);
    cyc(50, 12, 1'b0);
    cyc(200, 5, 1'b0);

    // Game over: darkened picture and frozen scroll.
    set_obj(200, -40, 150, 400, 150, 1'b1);
    new_state();
    cyc(50, 300, 1'b0);
    repeat (3) begin
      cyc(430, 6, 1'b0);
      cyc(430, 2, 1'b0);
      end_frame();
    end

    // Bird over pipe; wing animation across several frames.
    set_obj(200, 150, 0, 400, 150, 1'b0);
    new_state();
    cyc(205, 165, 1'b0);
    repeat (10) begin
      cyc(210, 165, 1'b0);
      cyc(209, 172, 1'b0);
      end_frame();
    end

    // Low bird must not wrap to the top rows.
    set_obj(500, 600, 0, 600, 0, 1'b0);
    new_state();
    cyc(4, 165, 1'b0);
    cyc(0, 160, 1'b0);

    // Randomized object states and pixels.
    for (int k = 0; k < 25; k++) begin
      set_obj(int'($urandom_range(0, 511)), int'($urandom_range(0, 691)) - 52,
              int'($urandom_range(0, 479)), int'($urandom_range(0, 691)) - 52,
              int'($urandom_range(0, 479)), ($urandom_range(0, 3) == 0));
      new_state();
      for (int n = 0; n < 30; n++) begin
        int r, c;
        r = int'($urandom_range(0, 479));
        c = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 639))
                                         : int'($urandom_range(140, 200));
        if ($urandom_range(0, 3) == 0) r = s_by + int'($urandom_range(0, 18));
        if (r > 479) r = 479;
        cyc(r, c, ($urandom_range(0, 7) == 0));
      end
    end

    // Mid-frame reset drops back to blanking with zeroed shadows.
    cyc(100, 100, 1'b0);
    @(posedge vga_clk);
    #1 rst = 1'b1;
    model_reset();
    @(posedge vga_clk);
    #1 rst = 1'b0;
    cyc(5, 165, 1'b0);
    cyc(200, 20, 1'b0);

    repeat (2) @(posedge vga_clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
